// File: rtl/melody_pkg.sv
// Shared definitions for the melody loader and the melody game core.
// Holds the loader state encoding, LFSR taps, the fixed ROM tune and the
// note packing geometry (8 slots of 4 bits, note in the low 3 bits of a slot).
package melody_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GEN,
        WRITE,
        GAP,
        START,
        PLAY
    } state_t;

    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [31:0] MELODY_ROM = 32'h3455_4400;
    localparam int          NOTE_W     = 3;
    localparam int          SLOT_W     = 4;
    localparam int          NOTE_COUNT = 8;

    // Bit position of the least significant bit of note slot k.
    function automatic int slot_offset(input int k);
        return SLOT_W * k;
    endfunction

endpackage

// File: rtl/melody_loader_if.sv
// Bus between the melody loader (master) and the melody game core (slave).
//   data_out     : packed 8-note melody, valid while write_enable is high
//   write_enable : one-cycle melody write strobe
//   game_start   : one-cycle game start strobe
//   core_reset   : one-cycle pulse, OR'd into the core reset at top level
//   game_end     : sticky game-complete flag from the core
interface melody_loader_if;

    logic [31:0] data_out;
    logic        write_enable;
    logic        game_start;
    logic        core_reset;
    logic        game_end;

    modport master (
        output data_out,
        output write_enable,
        output game_start,
        output core_reset,
        input  game_end
    );

    modport slave (
        input  data_out,
        input  write_enable,
        input  game_start,
        input  core_reset,
        output game_end
    );

endinterface

// File: rtl/melody_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// rising-edge detector.
//   clk, reset : system clock, asynchronous active-high reset
//   btn_raw    : raw asynchronous button level
//   press      : one-cycle pulse when the debounced level rises
// The debounced level flips only after DEBOUNCE_CYCLES consecutive
// synchronized samples that all differ from the current level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                // Any sample agreeing with the current level restarts the run.
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                press_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/melody_loader.sv
// Host-side producer for the melody memory-game core.
// On a debounced start press it pulses core_reset, builds an 8-note melody
// (from a free-running LFSR or the fixed ROM tune), writes it with a
// write_enable pulse, waits START_GAP cycles and pulses game_start. In PLAY
// it counts completed games (game_end) or restarts on a new press.
//   clk, reset  : system clock, asynchronous active-high reset
//   start_btn   : raw start button
//   melody_sel  : 0 = random melody, 1 = ROM melody (sampled in CLEAR)
//   bus         : core bus (data_out, write_enable, game_start, core_reset, game_end)
//   busy        : high whenever the FSM is not IDLE
//   round_count : completed games, saturating at 255
module melody_loader
    import melody_pkg::*;
#(
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          START_GAP       = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_btn,
    input  logic            melody_sel,
    melody_loader_if.master bus,
    output logic            busy,
    output logic [7:0]      round_count
);

    // An all-zero Galois LFSR never leaves zero.
    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int          GAP_N     = (START_GAP < 1) ? 1 : START_GAP;
    localparam int          GAP_W     = (GAP_N < 2) ? 1 : $clog2(GAP_N + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_N - 1);

    state_t             state_reg, state_next;
    logic [15:0]        lfsr_reg, lfsr_next;
    logic [2:0]         gen_idx_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic               sel_reg;
    logic [31:0]        shadow_reg, shadow_next;
    logic [31:0]        rand_fill;
    logic [31:0]        data_out_reg;
    logic [7:0]         round_count_reg;
    logic               press;
    logic               core_reset_c, write_enable_c, game_start_c, busy_c;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(start_btn),
        .press  (press)
    );

    // Free-running right-shift Galois LFSR.
    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);

    // Random-mode fill: the slot selected by gen_idx takes the current LFSR
    // note with its pad bit cleared; other slots keep their contents.
    for (genvar gi = 0; gi < NOTE_COUNT; gi++) begin : g_slot
        assign rand_fill[slot_offset(gi) +: SLOT_W] =
            (gen_idx_reg == 3'(gi)) ? {1'b0, lfsr_reg[NOTE_W-1:0]}
                                    : shadow_reg[slot_offset(gi) +: SLOT_W];
    end

    always_comb begin
        shadow_next = shadow_reg;
        if (state_reg == CLEAR) begin
            shadow_next = '0;
        end else if (state_reg == GEN) begin
            if (!sel_reg) begin
                shadow_next = rand_fill;
            end else if (gen_idx_reg == 3'd7) begin
                shadow_next = MELODY_ROM;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        core_reset_c   = 1'b0;
        write_enable_c = 1'b0;
        game_start_c   = 1'b0;
        busy_c         = (state_reg != IDLE);
        unique case (state_reg)
            IDLE:  if (press) state_next = CLEAR;
            CLEAR: begin
                core_reset_c = 1'b1;
                state_next   = GEN;
            end
            GEN:   if (gen_idx_reg == 3'd7) state_next = WRITE;
            WRITE: begin
                write_enable_c = 1'b1;
                state_next     = GAP;
            end
            GAP:   if (gap_cnt_reg == GAP_LAST) state_next = START;
            START: begin
                game_start_c = 1'b1;
                state_next   = PLAY;
            end
            PLAY: begin
                // A completed game takes priority over a simultaneous press.
                if (bus.game_end)   state_next = IDLE;
                else if (press)     state_next = CLEAR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            lfsr_reg        <= SEED_SAFE;
            gen_idx_reg     <= '0;
            gap_cnt_reg     <= '0;
            sel_reg         <= 1'b0;
            shadow_reg      <= '0;
            data_out_reg    <= '0;
            round_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            lfsr_reg   <= lfsr_next;
            shadow_reg <= shadow_next;
            if (state_reg == CLEAR) sel_reg <= melody_sel;
            gen_idx_reg <= (state_reg == GEN) ? gen_idx_reg + 3'd1 : 3'd0;
            gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 1'b1 : '0;
            // Load the finished melody on the way into WRITE so it is
            // already valid while write_enable is high.
            if (state_reg == GEN && gen_idx_reg == 3'd7) data_out_reg <= shadow_next;
            if (state_reg == PLAY && bus.game_end && round_count_reg != 8'hFF)
                round_count_reg <= round_count_reg + 8'd1;
        end
    end

    assign bus.data_out     = data_out_reg;
    assign bus.write_enable = write_enable_c;
    assign bus.game_start   = game_start_c;
    assign bus.core_reset   = core_reset_c;
    assign busy             = busy_c;
    assign round_count      = round_count_reg;

endmodule

// File: tb/tb_melody_loader.sv
module tb_melody_loader;
    import melody_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          DEB  = 4;
    localparam int          GAPC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_btn = 1'b0;
    logic       melody_sel = 1'b0;
    logic       busy;
    logic [7:0] round_count;

    melody_loader_if bus ();

    melody_loader #(
        .SEED           (SEED),
        .DEBOUNCE_CYCLES(DEB),
        .START_GAP      (GAPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_btn  (start_btn),
        .melody_sel (melody_sel),
        .bus        (bus),
        .busy       (busy),
        .round_count(round_count)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference LFSR: 16-bit right-shift Galois, taps 0xB400, runs every cycle.
    logic [15:0] lfsr_m;
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= SEED;
        else       lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    // Scoreboard consumer: every write must match the oldest expected melody.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.write_enable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {31'd0, bus.write_enable}, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    $display("[TB] write data_out=%h expected=%h", bus.data_out, e);
                    check("data_out", bus.data_out, e);
                    check("pad_bits", bus.data_out & 32'h8888_8888, 32'd0);
                end
            end
            if (bus.write_enable || bus.game_start || bus.core_reset)
                check("pulse_overlap",
                      32'({1'b0, bus.write_enable} + {1'b0, bus.game_start} + {1'b0, bus.core_reset}),
                      32'd1);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, bus.data_out, 32'd0);
        check({tag, "_we"}, {31'd0, bus.write_enable}, 32'd0);
        check({tag, "_gs"}, {31'd0, bus.game_start}, 32'd0);
        check({tag, "_cr"}, {31'd0, bus.core_reset}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rc"}, {24'd0, round_count}, 32'd0);
    endtask

    // Raise the button at a negedge; the debounced press lands at d=6,
    // so core_reset is at d=7, GEN d=8..15, write d=16, start d=19, PLAY d=20.
    task automatic press_seq(input logic sel, input logic from_play, input logic [7:0] rc_exp);
        logic [31:0] rnd;
        rnd = '0;
        melody_sel = sel;
        start_btn  = 1'b1;
        if (sel) exp_q.push_back(32'h3455_4400);
        for (int d = 1; d <= 20; d++) begin
            @(negedge clk);
            if (d == 8) start_btn = 1'b0;
            check("core_reset", {31'd0, bus.core_reset}, 32'(d == 7));
            check("write_enable", {31'd0, bus.write_enable}, 32'(d == 16));
            check("game_start", {31'd0, bus.game_start}, 32'(d == 19));
            check("busy", {31'd0, busy}, 32'(from_play || d >= 7));
            check("round_count", {24'd0, round_count}, {24'd0, rc_exp});
            if (!sel && d >= 8 && d <= 15) rnd[4*(d-8) +: 3] = lfsr_m[2:0];
            if (!sel && d == 15) exp_q.push_back(rnd);
        end
    endtask

    task automatic end_game(input logic [7:0] rc_exp);
        bus.game_end = 1'b1;
        @(negedge clk);
        bus.game_end = 1'b0;
        $display("[TB] game end round_count=%0d expected=%0d", round_count, rc_exp);
        check("busy_after_end", {31'd0, busy}, 32'd0);
        check("round_count_end", {24'd0, round_count}, {24'd0, rc_exp});
        check("core_reset_end", {31'd0, bus.core_reset}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.game_end = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Short glitches must never become a press.
        melody_sel = 1'b1;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 8; k++) begin
                start_btn = (k < 2);
                @(negedge clk);
                check_all_zero("glitch");
            end
        end
        $display("[TB] glitch burst done");

        // ROM melody, then a completed game.
        press_seq(1'b1, 1'b0, 8'd0);
        end_game(8'd1);

        // Random melody, then abort from PLAY with a ROM melody.
        press_seq(1'b0, 1'b0, 8'd1);
        press_seq(1'b1, 1'b1, 8'd1);
        end_game(8'd2);

        // Press and game_end together: the game end wins.
        press_seq(1'b1, 1'b0, 8'd2);
        start_btn = 1'b1;
        for (int d = 1; d <= 16; d++) begin
            @(negedge clk);
            check("sim_core_reset", {31'd0, bus.core_reset}, 32'd0);
            check("sim_we", {31'd0, bus.write_enable}, 32'd0);
            check("sim_busy", {31'd0, busy}, 32'(d < 7));
            check("sim_rc", {24'd0, round_count}, (d < 7) ? 32'd2 : 32'd3);
            if (d == 6) bus.game_end = 1'b1;
            if (d == 7) bus.game_end = 1'b0;
            if (d == 8) start_btn = 1'b0;
        end
        $display("[TB] simultaneous press/game_end done round_count=%0d", round_count);

        // Saturation of the game counter.
        n = 3;
        while (n < 260) begin
            press_seq(1'b1, 1'b0, (n > 255) ? 8'd255 : 8'(n));
            n++;
            end_game((n > 255) ? 8'd255 : 8'(n));
        end

        // Reset in the middle of GEN.
        melody_sel = 1'b0;
        start_btn  = 1'b1;
        for (int d = 1; d <= 10; d++) @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("mid_gen_reset");
        start_btn = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check_all_zero("in_reset");
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("after_reset");
        end
        press_seq(1'b0, 1'b0, 8'd0);
        end_game(8'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/melody_loader.md
Name: melody_loader

Overview:
- Host-side producer for the melody memory-game core; drives that core's data_in/write_enable/game_start.
- On a debounced start-button press: clears the core, builds a 32-bit packed 8-note melody (random LFSR or fixed ROM tune), writes it, then starts the game.
- Watches the core's game_end and counts completed games.

Parameters:
- SEED, 16'hACE1, LFSR reset value (0 is forced to 16'h0001)
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples needed to accept a button level
- START_GAP, 2, idle cycles between the write_enable pulse and the game_start pulse (min 1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start_btn  in  1  raw, asynchronous push button, active-high
- melody_sel  in  1  0 = random melody, 1 = fixed ROM melody; sampled in CLEAR
- game_end  in  1  core's sticky game-complete flag
- data_out  out  32  packed melody; note k in [4k+2:4k], bit 4k+3 always 0
- write_enable  out  1  one-cycle pulse, data_out valid
- game_start  out  1  one-cycle pulse
- core_reset  out  1  one-cycle pulse, OR'd into core reset at top level
- busy  out  1  high in any state except IDLE
- round_count  out  8  completed games, saturates at 255

Behaviour:
- Reset values (async, immediate, including mid-sequence):
  - data_out=0, write_enable=0, game_start=0, core_reset=0, busy=0, round_count=0
  - LFSR=SEED, state IDLE, debouncer output 0
- Button path:
  - 2-flop synchronizer feeds the debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES identical synchronized samples.
  - "press" is a one-cycle pulse on the debounced rising edge. Releases generate nothing.
- LFSR:
  - 16-bit Galois, taps mask 16'hB400, shifts right every clk in every state (free-running, so button timing supplies entropy).
  - Note source is lfsr[2:0].
- FSM states: IDLE, CLEAR, GEN, WRITE, GAP, START, PLAY.
  - IDLE: press -> CLEAR.
  - CLEAR (1 cycle): core_reset=1; latch melody_sel; clear shadow register; -> GEN.
  - GEN (exactly 8 cycles, 3-bit index 0..7):
    - random mode: shadow[4i+2:4i] <= lfsr[2:0] and shadow[4i+3] <= 0 at index i.
    - ROM mode: shadow <= MELODY_ROM (32'h3455_4400) on the last GEN cycle.
    - After index 7 -> WRITE.
  - WRITE (1 cycle): data_out <= shadow registered on entry to WRITE, so data_out is valid while write_enable=1; -> GAP.
  - GAP (START_GAP cycles) -> START.
  - START (1 cycle): game_start=1; -> PLAY.
  - PLAY:
    - game_end==1 -> round_count <= round_count+1 (hold at 255); -> IDLE.
    - press without game_end -> abort: CLEAR, no count.
    - game_end and press in the same cycle: game_end wins, count increments, press dropped, -> IDLE.
- Presses in CLEAR..START are ignored.
- data_out holds its value until the next WRITE.
- Timing, press pulse at cycle T:
  - core_reset at T+1
  - GEN T+2..T+9
  - write_enable at T+10
  - game_start at T+11+START_GAP (T+13 default)
- All pulse outputs are exactly one clk wide and never overlap.
- Zero-lock guard: if SEED==0 the LFSR resets to 16'h0001.

Decomposition:
- Shared package melody_pkg holds:
  - state enum
  - LFSR_TAPS=16'hB400
  - MELODY_ROM=32'h3455_4400
  - NOTE_W=3, SLOT_W=4, NOTE_COUNT=8
  - slot-offset function (4*k)
- The game core uses the same package for unpacking.
- One sub-module: btn_debounce (synchronizer, stability counter, rising-edge pulse; parameter DEBOUNCE_CYCLES).

Test Plan:
- Reset, then hold start_btn high 20 cycles with DEBOUNCE_CYCLES=4, melody_sel=1:
  - single press, core_reset at T+1, write_enable at T+10 with data_out=32'h3455_4400, game_start at T+13, busy high T+1 onward.
- 2-cycle glitches on start_btn with DEBOUNCE_CYCLES=4 -> no press, state stays IDLE, all outputs 0.
- melody_sel=0, SEED=16'hACE1, press at a known cycle:
  - data_out equals the bench LFSR model's 8 samples.
  - Bits 3,7,...,31 are all 0.
- In PLAY, raise game_end -> round_count 0->1, busy falls next cycle. Repeat 256 games -> round_count holds 255.
- In PLAY, press again -> second core_reset pulse, new write_enable and game_start, round_count unchanged. Press and game_end in the same cycle -> count increments, return to IDLE, no core_reset.
- Assert reset during GEN -> all outputs 0 immediately, no write_enable. A later press restarts the full sequence with LFSR reloaded to SEED.
